// File: rtl/seg7_demo_sequencer.sv
// seg7_demo_sequencer: picks the animation index and speed level for the
// 7-segment animation datapath.
//   auto mode   : plays each animation for LOOPS full loops, blanks the display
//                 for GAP_TICKS ticks, then advances to the next animation.
//   manual mode : entered on any button press (or auto_en low); the buttons step
//                 the animation and speed. Returns to auto after IDLE_TICKS idle ticks.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   tick              1 kHz timebase pulse
//   frame_wrap        datapath finished one full animation loop
//   auto_en           level, allows auto mode
//   btn_next/prev     debounced pulses, step the animation index (wrapping)
//   btn_faster/slower debounced pulses, step the speed level (saturating)
//   animation         selected animation index
//   speed_level       current speed level
//   blank             display forced off (auto gap)
//   auto_active       sequencer is in auto play or in the auto gap
//   ani_change        one-cycle pulse with every animation change
module seg7_demo_sequencer #(
  parameter int unsigned ANI_BIT    = 6,
  parameter int unsigned SPEED_BIT  = 5,
  parameter int unsigned SPEED_DEF  = 10,
  parameter int unsigned SPEED_MIN  = 1,
  parameter int unsigned SPEED_MAX  = 19,
  parameter int unsigned LOOPS      = 3,
  parameter int unsigned GAP_TICKS  = 250,
  parameter int unsigned IDLE_TICKS = 30000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 frame_wrap,
  input  logic                 auto_en,
  input  logic                 btn_next,
  input  logic                 btn_prev,
  input  logic                 btn_faster,
  input  logic                 btn_slower,
  output logic [ANI_BIT-1:0]   animation,
  output logic [SPEED_BIT-1:0] speed_level,
  output logic                 blank,
  output logic                 auto_active,
  output logic                 ani_change
);

  localparam int unsigned LOOP_W = (LOOPS > 1)      ? $clog2(LOOPS)      : 1;
  localparam int unsigned GAP_W  = (GAP_TICKS > 1)  ? $clog2(GAP_TICKS)  : 1;
  localparam int unsigned IDLE_W = (IDLE_TICKS > 1) ? $clog2(IDLE_TICKS) : 1;

  typedef enum logic [1:0] {
    S_AUTO   = 2'd0,
    S_GAP    = 2'd1,
    S_MANUAL = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [ANI_BIT-1:0]   animation_q, animation_d;
  logic [SPEED_BIT-1:0] speed_q, speed_d;
  logic                 blank_q, blank_d;
  logic                 auto_active_q, auto_active_d;
  logic                 ani_change_q, ani_change_d;
  logic [LOOP_W-1:0]    loop_cnt_q, loop_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;

  logic btn_any;
  logic step_up;
  logic step_dn;

  // Next-state, counter and output computation.
  always_comb begin
    state_d       = state_q;
    animation_d   = animation_q;
    speed_d       = speed_q;
    loop_cnt_d    = loop_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    ani_change_d  = 1'b0;

    btn_any = btn_next | btn_prev | btn_faster | btn_slower;
    // Opposing presses cancel, but still count as activity through btn_any.
    step_up = btn_next & ~btn_prev;
    step_dn = btn_prev & ~btn_next;

    // Speed buttons act in every state.
    if (btn_faster && !btn_slower && (speed_q > SPEED_BIT'(SPEED_MIN))) begin
      speed_d = speed_q - SPEED_BIT'(1);
    end else if (btn_slower && !btn_faster && (speed_q < SPEED_BIT'(SPEED_MAX))) begin
      speed_d = speed_q + SPEED_BIT'(1);
    end

    // Animation buttons act in every state; the index wraps naturally.
    if (step_up) begin
      animation_d  = animation_q + ANI_BIT'(1);
      ani_change_d = 1'b1;
    end else if (step_dn) begin
      animation_d  = animation_q - ANI_BIT'(1);
      ani_change_d = 1'b1;
    end

    case (state_q)
      S_AUTO: begin
        if (btn_any || !auto_en) begin
          state_d    = S_MANUAL;
          idle_cnt_d = '0;
        end else if (frame_wrap) begin
          if (loop_cnt_q == LOOP_W'(LOOPS - 1)) begin
            loop_cnt_d = '0;
            gap_cnt_d  = '0;
            state_d    = S_GAP;
          end else begin
            loop_cnt_d = loop_cnt_q + LOOP_W'(1);
          end
        end
      end

      S_GAP: begin
        if (btn_any || !auto_en) begin
          state_d    = S_MANUAL;
          idle_cnt_d = '0;
        end else if (tick) begin
          if (gap_cnt_q == GAP_W'(GAP_TICKS - 1)) begin
            // Buttons are absent on this path, so this is the only animation update.
            animation_d  = animation_q + ANI_BIT'(1);
            ani_change_d = 1'b1;
            loop_cnt_d   = '0;
            state_d      = S_AUTO;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
      end

      S_MANUAL: begin
        if (btn_any) begin
          idle_cnt_d = '0;
        end else if (tick) begin
          if (idle_cnt_q == IDLE_W'(IDLE_TICKS - 1)) begin
            // Saturated: wait here until auto_en allows the return.
            if (auto_en) begin
              state_d    = S_AUTO;
              loop_cnt_d = '0;
              idle_cnt_d = '0;
            end
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
        end
      end

      default: begin
        state_d = S_AUTO;
      end
    endcase

    blank_d       = (state_d == S_GAP);
    auto_active_d = (state_d != S_MANUAL);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_AUTO;
      animation_q   <= '0;
      speed_q       <= SPEED_BIT'(SPEED_DEF);
      blank_q       <= 1'b0;
      auto_active_q <= 1'b1;
      ani_change_q  <= 1'b0;
      loop_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      idle_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      animation_q   <= animation_d;
      speed_q       <= speed_d;
      blank_q       <= blank_d;
      auto_active_q <= auto_active_d;
      ani_change_q  <= ani_change_d;
      loop_cnt_q    <= loop_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end

  assign animation   = animation_q;
  assign speed_level = speed_q;
  assign blank       = blank_q;
  assign auto_active = auto_active_q;
  assign ani_change  = ani_change_q;

endmodule

// File: tb/tb_seg7_demo_sequencer.sv
// Testbench for seg7_demo_sequencer: directed scenarios with fixed expected
// values, followed by randomized traffic checked against a behavioural model.
module tb_seg7_demo_sequencer;

  localparam int ANI_BIT    = 6;
  localparam int SPEED_BIT  = 5;
  localparam int NANI       = 64;
  localparam int SPEED_DEF  = 10;
  localparam int SPEED_MIN  = 1;
  localparam int SPEED_MAX  = 19;
  localparam int LOOPS      = 2;
  localparam int GAP_TICKS  = 3;
  localparam int IDLE_TICKS = 5;

  logic                 clk;
  logic                 rst_n;
  logic                 tick;
  logic                 frame_wrap;
  logic                 auto_en;
  logic                 btn_next;
  logic                 btn_prev;
  logic                 btn_faster;
  logic                 btn_slower;
  logic [ANI_BIT-1:0]   animation;
  logic [SPEED_BIT-1:0] speed_level;
  logic                 blank;
  logic                 auto_active;
  logic                 ani_change;

  int vectors;
  int miscompares;

  seg7_demo_sequencer #(
    .ANI_BIT(ANI_BIT), .SPEED_BIT(SPEED_BIT), .SPEED_DEF(SPEED_DEF),
    .SPEED_MIN(SPEED_MIN), .SPEED_MAX(SPEED_MAX), .LOOPS(LOOPS),
    .GAP_TICKS(GAP_TICKS), .IDLE_TICKS(IDLE_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .frame_wrap(frame_wrap),
    .auto_en(auto_en), .btn_next(btn_next), .btn_prev(btn_prev),
    .btn_faster(btn_faster), .btn_slower(btn_slower),
    .animation(animation), .speed_level(speed_level), .blank(blank),
    .auto_active(auto_active), .ani_change(ani_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 = playing, 1 = gap, 2 = manual.
  int m_ani, m_speed, m_mode, m_loops_done, m_gap_ticks, m_idle_ticks;
  bit m_chg;

  task automatic model_reset();
    m_ani = 0; m_speed = SPEED_DEF; m_mode = 0; m_chg = 0;
    m_loops_done = 0; m_gap_ticks = 0; m_idle_ticks = 0;
  endtask

  task automatic model_step(input bit t, input bit fw, input bit ae,
                            input bit bn, input bit bp, input bit bf, input bit bs);
    bit any;
    any   = bn | bp | bf | bs;
    m_chg = 0;
    if (bf && !bs) m_speed = (m_speed - 1 < SPEED_MIN) ? SPEED_MIN : m_speed - 1;
    if (bs && !bf) m_speed = (m_speed + 1 > SPEED_MAX) ? SPEED_MAX : m_speed + 1;
    if (bn != bp) begin
      m_ani = (m_ani + (bn ? 1 : NANI - 1)) % NANI;
      m_chg = 1;
    end
    if (m_mode != 2 && (any || !ae)) begin
      m_mode = 2;
      m_idle_ticks = 0;
    end else if (m_mode == 0) begin
      if (fw) begin
        m_loops_done++;
        if (m_loops_done == LOOPS) begin
          m_loops_done = 0; m_gap_ticks = 0; m_mode = 1;
        end
      end
    end else if (m_mode == 1) begin
      if (t) begin
        m_gap_ticks++;
        if (m_gap_ticks == GAP_TICKS) begin
          m_ani = (m_ani + 1) % NANI; m_chg = 1; m_loops_done = 0; m_mode = 0;
        end
      end
    end else begin
      if (any) m_idle_ticks = 0;
      else if (t) begin
        if (m_idle_ticks + 1 >= IDLE_TICKS) begin
          m_idle_ticks = IDLE_TICKS - 1;
          if (ae) begin m_mode = 0; m_loops_done = 0; end
        end else begin
          m_idle_ticks++;
        end
      end
    end
  endtask

  // Apply one cycle of pulses, then sample 1 time unit after the edge.
  task automatic drive(input bit t, input bit fw, input bit bn, input bit bp,
                       input bit bf, input bit bs);
    tick = t; frame_wrap = fw; btn_next = bn; btn_prev = bp;
    btn_faster = bf; btn_slower = bs;
    @(posedge clk); #1;
    tick = 0; frame_wrap = 0; btn_next = 0; btn_prev = 0;
    btn_faster = 0; btn_slower = 0;
  endtask

  task automatic apply_reset();
    rst_n = 0; auto_en = 1;
    tick = 0; frame_wrap = 0; btn_next = 0; btn_prev = 0;
    btn_faster = 0; btn_slower = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (animation !== 6'd0) begin miscompares++; $display("FAIL reset_ani: got %0d expected 0", animation); end
    vectors++; if (speed_level !== 5'd10) begin miscompares++; $display("FAIL reset_speed: got %0d expected 10", speed_level); end
    vectors++; if (blank !== 1'b0) begin miscompares++; $display("FAIL reset_blank: got %b expected 0", blank); end
    vectors++; if (auto_active !== 1'b1) begin miscompares++; $display("FAIL reset_auto: got %b expected 1", auto_active); end
    vectors++; if (ani_change !== 1'b0) begin miscompares++; $display("FAIL reset_chg: got %b expected 0", ani_change); end
    drive(0, 0, 0, 0, 0, 0);
    vectors++; if ({animation, auto_active} !== {6'd0, 1'b1}) begin miscompares++; $display("FAIL reset_idle_cycle: got ani=%0d auto=%b expected ani=0 auto=1", animation, auto_active); end
  endtask

  task automatic test_auto_cycle();
    apply_reset();
    drive(0, 1, 0, 0, 0, 0);
    vectors++; if (blank !== 1'b0) begin miscompares++; $display("FAIL auto_wrap1_blank: got %b expected 0", blank); end
    drive(0, 1, 0, 0, 0, 0);
    vectors++; if ({blank, auto_active} !== 2'b11) begin miscompares++; $display("FAIL auto_wrap2_gap: got blank=%b auto=%b expected 1 1", blank, auto_active); end
    drive(0, 1, 0, 0, 0, 0);  // frame_wrap ignored in the gap
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    vectors++; if ({blank, animation} !== {1'b1, 6'd0}) begin miscompares++; $display("FAIL gap_tick2: got blank=%b ani=%0d expected 1 0", blank, animation); end
    drive(1, 0, 0, 0, 0, 0);
    vectors++; if ({blank, animation, ani_change, auto_active} !== {1'b0, 6'd1, 1'b1, 1'b1}) begin miscompares++; $display("FAIL gap_end: got blank=%b ani=%0d chg=%b auto=%b expected 0 1 1 1", blank, animation, ani_change, auto_active); end
    drive(0, 0, 0, 0, 0, 0);
    vectors++; if (ani_change !== 1'b0) begin miscompares++; $display("FAIL gap_end_pulse_width: got %b expected 0", ani_change); end
  endtask

  task automatic test_manual_wrap();
    apply_reset();
    drive(0, 0, 0, 1, 0, 0);
    vectors++; if ({animation, auto_active, ani_change} !== {6'd63, 1'b0, 1'b1}) begin miscompares++; $display("FAIL prev_wrap: got ani=%0d auto=%b chg=%b expected 63 0 1", animation, auto_active, ani_change); end
    drive(0, 0, 1, 0, 0, 0);
    vectors++; if ({animation, ani_change} !== {6'd0, 1'b1}) begin miscompares++; $display("FAIL next_wrap: got ani=%0d chg=%b expected 0 1", animation, ani_change); end
    drive(0, 0, 1, 1, 0, 0);
    vectors++; if ({animation, ani_change} !== {6'd0, 1'b0}) begin miscompares++; $display("FAIL next_prev_cancel: got ani=%0d chg=%b expected 0 0", animation, ani_change); end
    apply_reset();
    drive(0, 0, 1, 1, 0, 0);
    vectors++; if ({animation, auto_active, ani_change} !== {6'd0, 1'b0, 1'b0}) begin miscompares++; $display("FAIL both_is_activity: got ani=%0d auto=%b chg=%b expected 0 0 0", animation, auto_active, ani_change); end
  endtask

  task automatic test_speed();
    apply_reset();
    repeat (12) drive(0, 0, 0, 0, 1, 0);
    vectors++; if (speed_level !== 5'd1) begin miscompares++; $display("FAIL speed_min_sat: got %0d expected 1", speed_level); end
    repeat (20) drive(0, 0, 0, 0, 0, 1);
    vectors++; if (speed_level !== 5'd19) begin miscompares++; $display("FAIL speed_max_sat: got %0d expected 19", speed_level); end
    repeat (4) drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 1);
    vectors++; if (speed_level !== 5'd15) begin miscompares++; $display("FAIL speed_both: got %0d expected 15", speed_level); end
  endtask

  task automatic test_idle_return();
    apply_reset();
    drive(0, 0, 1, 0, 0, 0);
    repeat (4) drive(1, 0, 0, 0, 0, 0);
    vectors++; if (auto_active !== 1'b0) begin miscompares++; $display("FAIL idle_tick4: got %b expected 0", auto_active); end
    drive(1, 0, 0, 0, 0, 0);
    vectors++; if (auto_active !== 1'b1) begin miscompares++; $display("FAIL idle_tick5: got %b expected 1", auto_active); end
    drive(0, 0, 1, 0, 0, 0);
    auto_en = 0;
    repeat (8) drive(1, 0, 0, 0, 0, 0);
    vectors++; if (auto_active !== 1'b0) begin miscompares++; $display("FAIL idle_auto_en_low: got %b expected 0", auto_active); end
    auto_en = 1;
    drive(0, 0, 0, 0, 0, 0);
    vectors++; if (auto_active !== 1'b0) begin miscompares++; $display("FAIL idle_wait_tick: got %b expected 0", auto_active); end
    drive(1, 0, 0, 0, 0, 0);
    vectors++; if (auto_active !== 1'b1) begin miscompares++; $display("FAIL idle_after_rise: got %b expected 1", auto_active); end
  endtask

  task automatic test_gap_button();
    apply_reset();
    drive(0, 0, 0, 0, 0, 1);
    repeat (4) drive(0, 0, 1, 0, 0, 0);
    repeat (5) drive(1, 0, 0, 0, 0, 0);
    vectors++; if ({animation, auto_active} !== {6'd4, 1'b1}) begin miscompares++; $display("FAIL gapbtn_setup: got ani=%0d auto=%b expected 4 1", animation, auto_active); end
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0);
    vectors++; if ({blank, animation, auto_active, ani_change} !== {1'b0, 6'd5, 1'b0, 1'b1}) begin miscompares++; $display("FAIL gapbtn_exit: got blank=%b ani=%0d auto=%b chg=%b expected 0 5 0 1", blank, animation, auto_active, ani_change); end
    repeat (5) drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    vectors++; if (blank !== 1'b1) begin miscompares++; $display("FAIL gaprst_in_gap: got %b expected 1", blank); end
    #2 rst_n = 0;
    #1;
    vectors++; if ({animation, speed_level, blank, auto_active, ani_change} !== {6'd0, 5'd10, 1'b0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL gap_async_reset: got ani=%0d spd=%0d blank=%b auto=%b chg=%b expected 0 10 0 1 0", animation, speed_level, blank, auto_active, ani_change);
    end
    @(posedge clk); #1 rst_n = 1;
  endtask

  task automatic test_random();
    bit t, fw, bn, bp, bf, bs;
    apply_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 499) begin
        #2 rst_n = 0;
        model_reset();
        @(posedge clk); #1 rst_n = 1;
      end else begin
        t  = ($urandom_range(0, 2) == 0);
        fw = ($urandom_range(0, 3) == 0);
        bn = ($urandom_range(0, 29) == 0);
        bp = ($urandom_range(0, 29) == 0);
        bf = ($urandom_range(0, 24) == 0);
        bs = ($urandom_range(0, 24) == 0);
        auto_en = ($urandom_range(0, 39) != 0);
        model_step(t, fw, auto_en, bn, bp, bf, bs);
        drive(t, fw, bn, bp, bf, bs);
      end
      vectors++; if (animation !== 6'(m_ani)) begin miscompares++; $display("FAIL rand_ani @%0d: got %0d expected %0d", i, animation, m_ani); end
      vectors++; if (speed_level !== 5'(m_speed)) begin miscompares++; $display("FAIL rand_speed @%0d: got %0d expected %0d", i, speed_level, m_speed); end
      vectors++; if (blank !== (m_mode == 1)) begin miscompares++; $display("FAIL rand_blank @%0d: got %b expected %b", i, blank, m_mode == 1); end
      vectors++; if (auto_active !== (m_mode != 2)) begin miscompares++; $display("FAIL rand_auto @%0d: got %b expected %b", i, auto_active, m_mode != 2); end
      vectors++; if (ani_change !== m_chg) begin miscompares++; $display("FAIL rand_chg @%0d: got %b expected %b", i, ani_change, m_chg); end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_auto_cycle();
    test_manual_wrap();
    test_speed();
    test_idle_return();
    test_gap_button();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
